// File: rtl/hub75_bcm_scan_driver.sv
// HUB75 bit-coded-modulation scan driver: overlaps the shift of the next bitplane with the
// display period of the current one and swaps frame buffers only at frame boundaries.
// state | meaning
// IDLE  | disabled, outputs blanked, shadow config latched on ctrl_en
// CHECK | validate shadow config
// HALT  | invalid config, blanked until ctrl_en drops
// FILL  | shift the first plane before anything is shown
// BL    | blank, present row address
// LT    | latch pulse, load plane timers, start shifting the next plane
// SHOW  | on-time then blanked remainder; leave when period and shift are both done
module hub75_bcm_scan_driver #(
   parameter int N_CHAINS       = 2,
   parameter int N_ROWS_MAX     = 64,
   parameter int N_COLS_MAX     = 256,
   parameter int BITDEPTH_MAX   = 8,
   parameter int LSB_BLANK_MAX  = 255,
   parameter int CTRL_REG_WIDTH = 32,
   parameter int ADDR_W         = $clog2(N_ROWS_MAX*N_COLS_MAX)-1
) (
   input  logic                            clk,
   input  logic                            ctrl_rst,
   input  logic                            ctrl_en,
   input  logic [CTRL_REG_WIDTH-1:0]       ctrl_n_rows,
   input  logic [CTRL_REG_WIDTH-1:0]       ctrl_n_cols,
   input  logic [CTRL_REG_WIDTH-1:0]       ctrl_bitdepth,
   input  logic [CTRL_REG_WIDTH-1:0]       ctrl_lsb_blank,
   input  logic [CTRL_REG_WIDTH-1:0]       ctrl_brightness,
   input  logic                            ctrl_scan_mode,
   input  logic                            ctrl_buffer_req,
   output logic                            stat_buffer,
   output logic                            stat_frame_done,
   output logic                            stat_cfg_err,
   output logic                            mem_en,
   output logic                            mem_buffer,
   output logic [ADDR_W-1:0]               mem_addr,
   output logic [$clog2(BITDEPTH_MAX)-1:0] mem_bit,
   input  logic [6*N_CHAINS-1:0]           mem_din,
   output logic                            disp_clk,
   output logic                            disp_blank,
   output logic                            disp_latch,
   output logic [$clog2(N_ROWS_MAX)-2:0]   disp_addr,
   output logic [6*N_CHAINS-1:0]           disp_rgb
);

   localparam int RA_W  = $clog2(N_ROWS_MAX)-1;
   localparam int BW    = $clog2(BITDEPTH_MAX);
   localparam int PER_W = $clog2(LSB_BLANK_MAX+1) + BITDEPTH_MAX - 1;
   localparam int CNT_W = $clog2(2*N_COLS_MAX+1);
   localparam int DW    = 6*N_CHAINS;
   localparam int CW    = CTRL_REG_WIDTH;

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_HALT, S_FILL, S_BL, S_LT, S_SHOW} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     rows_q, rows_d, cols_q, cols_d, depth_q, depth_d;
   logic [CW-1:0]     lsb_q, lsb_d, bri_q, bri_d;
   logic              zig_q, zig_d;
   logic [RA_W-1:0]   cur_k_q, cur_k_d, sh_k_q, sh_k_d;
   logic [BW-1:0]     cur_b_q, cur_b_d, sh_b_q, sh_b_d;
   logic              sh_busy_q, sh_busy_d;
   logic [CNT_W-1:0]  sh_cnt_q, sh_cnt_d;
   logic [PER_W-1:0]  per_q, per_d, on_q, on_d;
   logic              frame_seen_q, frame_seen_d;
   logic              stat_buffer_q, stat_buffer_d, stat_frame_done_q, stat_frame_done_d;
   logic              stat_cfg_err_q, stat_cfg_err_d;
   logic              disp_clk_q, disp_clk_d, disp_blank_q, disp_blank_d;
   logic              disp_latch_q, disp_latch_d;
   logic [RA_W-1:0]   disp_addr_q, disp_addr_d;
   logic [DW-1:0]     disp_rgb_q, disp_rgb_d;

   logic [RA_W-1:0]   s_m1, nx_k, sh_row;
   logic [BW-1:0]     d_m1, nx_b;
   logic [PER_W-1:0]  per_base, on_base;
   logic              sh_last, sh_done, cfg_bad;

   function automatic logic [RA_W-1:0] row_of(input logic [RA_W-1:0] k, input logic zig,
                                               input logic [RA_W-1:0] sm1);
      if (!zig)  return k;
      if (!k[0]) return k >> 1;
      return sm1 - (k >> 1);
   endfunction

   assign s_m1     = RA_W'((rows_q >> 1) - CW'(1));
   assign d_m1     = BW'(depth_q - CW'(1));
   assign nx_b     = (cur_b_q == d_m1) ? '0 : cur_b_q + BW'(1);
   assign nx_k     = (cur_b_q != d_m1) ? cur_k_q : ((cur_k_q == s_m1) ? '0 : cur_k_q + RA_W'(1));
   assign per_base = PER_W'(lsb_q);
   assign on_base  = (lsb_q > bri_q) ? PER_W'(lsb_q - bri_q) : '0;
   assign sh_row   = row_of(sh_k_q, zig_q, s_m1);
   assign sh_last  = sh_busy_q && (sh_cnt_q == CNT_W'(cols_q << 1));
   assign sh_done  = !sh_busy_q || sh_last;

   assign cfg_bad = (rows_q == '0) || rows_q[0] || (rows_q > CW'(N_ROWS_MAX)) ||
                    (cols_q == '0) || (cols_q > CW'(N_COLS_MAX)) ||
                    (depth_q == '0) || (depth_q > CW'(BITDEPTH_MAX)) ||
                    (lsb_q == '0) || (lsb_q > CW'(LSB_BLANK_MAX));

   // Even shift counts fetch a column, odd counts present it with disp_clk low.
   assign mem_en     = sh_busy_q && !sh_cnt_q[0] && !sh_last;
   assign mem_addr   = ADDR_W'(sh_row) * ADDR_W'(cols_q) + ADDR_W'(sh_cnt_q[CNT_W-1:1]);
   assign mem_bit    = sh_b_q;
   assign mem_buffer = stat_buffer_q;

   assign stat_buffer     = stat_buffer_q;
   assign stat_frame_done = stat_frame_done_q;
   assign stat_cfg_err    = stat_cfg_err_q;
   assign disp_clk        = disp_clk_q;
   assign disp_blank      = disp_blank_q;
   assign disp_latch      = disp_latch_q;
   assign disp_addr       = disp_addr_q;
   assign disp_rgb        = disp_rgb_q;

   always_comb begin
      state_d = state_q;
      rows_d = rows_q; cols_d = cols_q; depth_d = depth_q; lsb_d = lsb_q; bri_d = bri_q;
      zig_d = zig_q;
      cur_k_d = cur_k_q; cur_b_d = cur_b_q; sh_k_d = sh_k_q; sh_b_d = sh_b_q;
      sh_busy_d = sh_busy_q; sh_cnt_d = sh_cnt_q;
      per_d = per_q; on_d = on_q;
      frame_seen_d = frame_seen_q;
      stat_buffer_d = stat_buffer_q; stat_frame_done_d = 1'b0; stat_cfg_err_d = stat_cfg_err_q;
      disp_clk_d = 1'b0; disp_blank_d = 1'b1; disp_latch_d = 1'b0;
      disp_addr_d = disp_addr_q; disp_rgb_d = disp_rgb_q;

      if (sh_busy_q) begin
         sh_cnt_d  = sh_cnt_q + CNT_W'(1);
         sh_busy_d = !sh_last;
         if (sh_cnt_q[0]) disp_rgb_d = mem_din;
         else             disp_clk_d = (sh_cnt_q != '0);
      end

      unique case (state_q)
         S_IDLE: begin
            if (ctrl_en) begin
               rows_d = ctrl_n_rows; cols_d = ctrl_n_cols; depth_d = ctrl_bitdepth;
               lsb_d = ctrl_lsb_blank; bri_d = ctrl_brightness; zig_d = ctrl_scan_mode;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (cfg_bad) begin
               stat_cfg_err_d = 1'b1;
               state_d        = S_HALT;
            end else begin
               stat_cfg_err_d = 1'b0;
               stat_buffer_d  = ctrl_buffer_req;
               cur_k_d = '0; cur_b_d = '0; sh_k_d = '0; sh_b_d = '0;
               frame_seen_d = 1'b0;
               sh_busy_d = 1'b1; sh_cnt_d = '0;
               state_d = S_FILL;
            end
         end
         S_HALT: ;
         S_FILL: if (sh_done) state_d = S_BL;
         S_BL: begin
            disp_addr_d = row_of(cur_k_q, zig_q, s_m1);
            // The first plane of the new frame was prefetched from the old buffer.
            if (frame_seen_q && (cur_k_q == '0) && (cur_b_q == '0)) begin
               stat_frame_done_d = 1'b1;
               stat_buffer_d     = ctrl_buffer_req;
            end
            state_d = S_LT;
         end
         S_LT: begin
            disp_latch_d = 1'b1;
            per_d = per_base << cur_b_q;
            on_d  = on_base << cur_b_q;
            sh_k_d = nx_k; sh_b_d = nx_b;
            sh_busy_d = 1'b1; sh_cnt_d = '0;
            state_d = S_SHOW;
         end
         S_SHOW: begin
            disp_blank_d = (on_q == '0);
            if (on_q != '0)  on_d  = on_q - PER_W'(1);
            if (per_q != '0) per_d = per_q - PER_W'(1);
            if ((per_q <= PER_W'(1)) && sh_done) begin
               cur_k_d = sh_k_q; cur_b_d = sh_b_q;
               if ((sh_k_q == '0) && (sh_b_q == '0)) frame_seen_d = 1'b1;
               state_d = S_BL;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (!ctrl_en) begin
         state_d = S_IDLE;
         disp_blank_d = 1'b1; disp_clk_d = 1'b0; disp_latch_d = 1'b0;
         sh_busy_d = 1'b0;
         stat_frame_done_d = 1'b0;
         stat_buffer_d = stat_buffer_q;
      end
   end

   always_ff @(posedge clk) begin
      if (ctrl_rst) begin
         state_q <= S_IDLE;
         rows_q <= '0; cols_q <= '0; depth_q <= '0; lsb_q <= '0; bri_q <= '0; zig_q <= 1'b0;
         cur_k_q <= '0; cur_b_q <= '0; sh_k_q <= '0; sh_b_q <= '0;
         sh_busy_q <= 1'b0; sh_cnt_q <= '0; per_q <= '0; on_q <= '0;
         frame_seen_q <= 1'b0;
         stat_buffer_q <= 1'b0; stat_frame_done_q <= 1'b0; stat_cfg_err_q <= 1'b0;
         disp_clk_q <= 1'b0; disp_blank_q <= 1'b1; disp_latch_q <= 1'b0;
         disp_addr_q <= '0; disp_rgb_q <= '0;
      end else begin
         state_q <= state_d;
         rows_q <= rows_d; cols_q <= cols_d; depth_q <= depth_d; lsb_q <= lsb_d; bri_q <= bri_d;
         zig_q <= zig_d;
         cur_k_q <= cur_k_d; cur_b_q <= cur_b_d; sh_k_q <= sh_k_d; sh_b_q <= sh_b_d;
         sh_busy_q <= sh_busy_d; sh_cnt_q <= sh_cnt_d; per_q <= per_d; on_q <= on_d;
         frame_seen_q <= frame_seen_d;
         stat_buffer_q <= stat_buffer_d; stat_frame_done_q <= stat_frame_done_d;
         stat_cfg_err_q <= stat_cfg_err_d;
         disp_clk_q <= disp_clk_d; disp_blank_q <= disp_blank_d; disp_latch_q <= disp_latch_d;
         disp_addr_q <= disp_addr_d; disp_rgb_q <= disp_rgb_d;
      end
   end

endmodule

// File: tb/tb_hub75_bcm_scan_driver.sv
// Directed bench for hub75_bcm_scan_driver: records every latch pulse with its row, spacing,
// on-time, shift-clock count, frame pulse, buffer and last shifted pixel, then checks them.
module tb_hub75_bcm_scan_driver;
   localparam int DW = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          ctrl_rst, ctrl_en, ctrl_scan_mode, ctrl_buffer_req;
   logic [31:0]   ctrl_n_rows, ctrl_n_cols, ctrl_bitdepth, ctrl_lsb_blank, ctrl_brightness;
   logic          stat_buffer, stat_frame_done, stat_cfg_err, mem_en, mem_buffer;
   logic [12:0]   mem_addr;
   logic [2:0]    mem_bit;
   logic [DW-1:0] mem_din = '0;
   logic [DW-1:0] disp_rgb;
   logic          disp_clk, disp_blank, disp_latch;
   logic [4:0]    disp_addr;

   hub75_bcm_scan_driver dut (
      .clk(clk), .ctrl_rst(ctrl_rst), .ctrl_en(ctrl_en),
      .ctrl_n_rows(ctrl_n_rows), .ctrl_n_cols(ctrl_n_cols), .ctrl_bitdepth(ctrl_bitdepth),
      .ctrl_lsb_blank(ctrl_lsb_blank), .ctrl_brightness(ctrl_brightness),
      .ctrl_scan_mode(ctrl_scan_mode), .ctrl_buffer_req(ctrl_buffer_req),
      .stat_buffer(stat_buffer), .stat_frame_done(stat_frame_done), .stat_cfg_err(stat_cfg_err),
      .mem_en(mem_en), .mem_buffer(mem_buffer), .mem_addr(mem_addr), .mem_bit(mem_bit),
      .mem_din(mem_din), .disp_clk(disp_clk), .disp_blank(disp_blank),
      .disp_latch(disp_latch), .disp_addr(disp_addr), .disp_rgb(disp_rgb)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Pixel word is {addr[8:0], bit}, inverted for buffer 1.
   function automatic logic [DW-1:0] pix(input logic [12:0] a, input logic [2:0] b, input logic bsel);
      logic [DW-1:0] v;
      v = {a[8:0], b};
      return bsel ? ~v : v;
   endfunction

   always @(posedge clk) if (mem_en) mem_din <= pix(mem_addr, mem_bit, mem_buffer);

   int l_addr[256], l_gap[256], l_on[256], l_rise[256], l_fd[256], l_buf[256], l_rgb[256];
   int n_lat = 0;
   int gap_c = 0, on_c = 0, rise_c = 0, fd_c = 0, last_rgb = 0;
   logic prev_clk = 1'b0;

   always @(negedge clk) begin
      if (!ctrl_en) begin
         gap_c = 0; on_c = 0; rise_c = 0; fd_c = 0;
      end else begin
         gap_c++;
         if (!disp_blank) on_c++;
         if (disp_clk && !prev_clk) begin rise_c++; last_rgb = int'(disp_rgb); end
         if (stat_frame_done) fd_c = 1;
         if (disp_latch && n_lat < 256) begin
            l_addr[n_lat] = int'(disp_addr); l_gap[n_lat] = gap_c; l_on[n_lat] = on_c;
            l_rise[n_lat] = rise_c; l_fd[n_lat] = fd_c; l_buf[n_lat] = int'(mem_buffer);
            l_rgb[n_lat] = last_rgb;
            n_lat++;
            gap_c = 0; on_c = 0; rise_c = 0; fd_c = 0;
         end
      end
      prev_clk = disp_clk;
   end

   int base = 0;

   task automatic start_run(input int r, input int c, input int d, input int l, input int br,
                            input logic z, input logic q);
      ctrl_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      ctrl_n_rows = r; ctrl_n_cols = c; ctrl_bitdepth = d; ctrl_lsb_blank = l;
      ctrl_brightness = br; ctrl_scan_mode = z; ctrl_buffer_req = q;
      base = n_lat;
      ctrl_en = 1'b1;
   endtask

   task automatic wait_lat(input int target);
      int t;
      t = 0;
      while (n_lat < target && t < 3000) begin
         @(negedge clk); #1;
         t++;
      end
      if (n_lat < target) check("latch_timeout", n_lat, target);
   endtask

   int ea[5], eg[4], eo[4], er[4];
   int fsum;

   initial begin
      ctrl_rst = 1'b1; ctrl_en = 1'b0; ctrl_scan_mode = 1'b0; ctrl_buffer_req = 1'b0;
      ctrl_n_rows = 0; ctrl_n_cols = 0; ctrl_bitdepth = 0; ctrl_lsb_blank = 0; ctrl_brightness = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_blank", disp_blank, 1);
      check("rst_clk", disp_clk, 0);
      check("rst_latch", disp_latch, 0);
      check("rst_addr", disp_addr, 0);
      check("rst_rgb", disp_rgb, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_stat", {stat_buffer, stat_frame_done, stat_cfg_err}, 0);
      @(posedge clk); #1;
      ctrl_rst = 1'b0;

      // Linear 4x4, two planes, lsb 20
      start_run(4, 4, 2, 20, 0, 1'b0, 1'b0);
      wait_lat(base + 5);
      ea = '{0, 0, 1, 1, 0};
      eg = '{22, 42, 22, 42};
      eo = '{20, 40, 20, 40};
      er = '{24, 25, 56, 57};
      for (int i = 0; i < 5; i++) check("t1_addr", l_addr[base+i], ea[i]);
      for (int i = 0; i < 4; i++) check("t1_rise", l_rise[base+i], 4);
      for (int i = 0; i < 4; i++) check("t1_rgb", l_rgb[base+i], er[i]);
      for (int i = 1; i < 5; i++) check("t1_gap", l_gap[base+i], eg[i-1]);
      for (int i = 1; i < 5; i++) check("t1_on", l_on[base+i], eo[i-1]);
      fsum = l_fd[base+1] + l_fd[base+2] + l_fd[base+3];
      check("t1_fd_mid", fsum, 0);
      check("t1_fd_wrap", l_fd[base+4], 1);

      // Dimming by 5
      start_run(4, 4, 2, 20, 5, 1'b0, 1'b0);
      wait_lat(base + 3);
      check("t2_on0", l_on[base+1], 15);
      check("t2_on1", l_on[base+2], 30);
      check("t2_gap0", l_gap[base+1], 22);
      check("t2_gap1", l_gap[base+2], 42);

      // Brightness above lsb keeps the panel dark
      start_run(2, 4, 1, 20, 25, 1'b0, 1'b0);
      wait_lat(base + 2);
      check("t2b_on", l_on[base+1], 0);
      check("t2b_gap", l_gap[base+1], 22);

      // Zigzag 8 rows, buffer 1
      start_run(8, 4, 1, 10, 0, 1'b1, 1'b1);
      wait_lat(base + 5);
      ea = '{0, 3, 1, 2, 0};
      for (int i = 0; i < 5; i++) check("t3_addr", l_addr[base+i], ea[i]);
      fsum = l_fd[base+1] + l_fd[base+2] + l_fd[base+3];
      check("t3_fd_mid", fsum, 0);
      check("t3_fd_wrap", l_fd[base+4], 1);
      check("t3_gap", l_gap[base+1], 12);
      check("t3_rgb", l_rgb[base+1], 3975);
      check("t3_stat_buf", stat_buffer, 1);

      // Shift longer than the period
      start_run(4, 64, 1, 4, 0, 1'b0, 1'b0);
      wait_lat(base + 3);
      check("t4_gap0", l_gap[base+1], 131);
      check("t4_gap1", l_gap[base+2], 131);
      check("t4_on", l_on[base+1], 4);
      check("t4_rise", l_rise[base+1], 64);
      check("t4_rgb", l_rgb[base+1], 1016);

      // Buffer request mid-frame
      start_run(4, 4, 2, 20, 0, 1'b0, 1'b0);
      wait_lat(base + 2);
      @(posedge clk); #1;
      ctrl_buffer_req = 1'b1;
      check("t5_stat_buf_hold", stat_buffer, 0);
      wait_lat(base + 5);
      check("t5_buf_l2", l_buf[base+2], 0);
      check("t5_buf_l3", l_buf[base+3], 0);
      check("t5_buf_l4", l_buf[base+4], 1);
      check("t5_fd_l4", l_fd[base+4], 1);
      check("t5_stat_buf", stat_buffer, 1);
      @(posedge clk); #1;
      ctrl_rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("t5_rst_buf", stat_buffer, 0);
      check("t5_rst_blank", disp_blank, 1);
      check("t5_rst_clk", disp_clk, 0);
      check("t5_rst_mem_en", mem_en, 0);
      @(posedge clk); #1;
      ctrl_rst = 1'b0;

      // Odd rows halt, then recovery
      start_run(3, 4, 2, 20, 0, 1'b0, 1'b0);
      repeat (20) @(negedge clk);
      #1;
      check("t6_err", stat_cfg_err, 1);
      check("t6_blank", disp_blank, 1);
      check("t6_rise", rise_c, 0);
      check("t6_nolatch", n_lat, base);
      start_run(4, 4, 2, 20, 0, 1'b0, 1'b0);
      wait_lat(base + 1);
      check("t6_err_clr", stat_cfg_err, 0);
      check("t6_addr", l_addr[base], 0);

      start_run(4, 4, 9, 20, 0, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      #1;
      check("t7_depth_err", stat_cfg_err, 1);
      start_run(4, 4, 2, 0, 0, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      #1;
      check("t7_lsb_err", stat_cfg_err, 1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/hub75_bcm_scan_driver.md
Name: hub75_bcm_scan_driver

Overview:
- Next-generation HUB75 bit-coded-modulation (BCM) panel driver.
- Drives N_CHAINS parallel panel chains from one shared frame-buffer read port.
- Adds the following over the first-generation driver:
  - config registers latched at start;
  - linear or zigzag row scan;
  - shifting of the next bitplane overlapped with display of the current one;
  - buffer swap only at frame boundary, with status outputs.
- Sits between the AXI-mapped control registers, the dual-buffer BRAM, and the panel connector pins.

Parameters:
N_CHAINS, 2, number of parallel HUB75 chains; each chain carries R0 G0 B0 R1 G1 B1.
N_ROWS_MAX, 64, maximum panel rows; scan rows = rows/2.
N_COLS_MAX, 256, maximum columns per chain (panels x columns).
BITDEPTH_MAX, 8, maximum bits per colour.
LSB_BLANK_MAX, 255, maximum LSB period in clk cycles.
CTRL_REG_WIDTH, 32, width of the control inputs.
ADDR_W, $clog2(N_ROWS_MAX*N_COLS_MAX)-1, width of mem_addr.

Ports:
clk  in  1  global clock
ctrl_rst  in  1  synchronous, active-high reset
ctrl_en  in  1  run enable
ctrl_n_rows  in  CTRL_REG_WIDTH  panel rows; must be even
ctrl_n_cols  in  CTRL_REG_WIDTH  columns per chain
ctrl_bitdepth  in  CTRL_REG_WIDTH  bits per colour
ctrl_lsb_blank  in  CTRL_REG_WIDTH  LSB period in clk cycles
ctrl_brightness  in  CTRL_REG_WIDTH  dimming: cycles subtracted from the LSB on-time
ctrl_scan_mode  in  1  0 = linear scan, 1 = zigzag scan
ctrl_buffer_req  in  1  buffer to display starting from the next frame
stat_buffer  out  1  buffer currently being read
stat_frame_done  out  1  one-cycle pulse at each frame boundary
stat_cfg_err  out  1  latched configuration is invalid
mem_en  out  1  BRAM read enable
mem_buffer  out  1  BRAM buffer select
mem_addr  out  ADDR_W  scan_row*n_cols + col
mem_bit  out  $clog2(BITDEPTH_MAX)  bitplane index
mem_din  in  6*N_CHAINS  read data; 1-cycle latency; chain k occupies bits [6k+5:6k]
disp_clk  out  1  panel shift clock
disp_blank  out  1  OE, active-high blank
disp_latch  out  1  panel latch
disp_addr  out  $clog2(N_ROWS_MAX)-1  panel row address
disp_rgb  out  6*N_CHAINS  panel data; same packing as mem_din

Behaviour:

Reset values:
- disp_blank = 1; disp_clk, disp_latch, disp_addr, disp_rgb = 0.
- mem_en = 0; stat_* = 0; stat_buffer = 0.
- FSM = IDLE.

IDLE:
- On ctrl_en = 1, latch all ctrl_* into shadow registers and go to CHECK. Shadow registers never change while running.

CHECK (1 cycle):
- Error if any of:
  - n_rows = 0, odd, or > N_ROWS_MAX;
  - n_cols = 0 or > N_COLS_MAX;
  - bitdepth = 0 or > BITDEPTH_MAX;
  - lsb_blank = 0 or > LSB_BLANK_MAX.
- On error: stat_cfg_err = 1, go to HALT (blanked; stays until ctrl_en = 0 or reset).
- Otherwise: clear stat_cfg_err, load stat_buffer from ctrl_buffer_req, scan index k = 0, bit = 0, go to SHIFT.

Scan order (S = n_rows/2):
- Linear: row(k) = k.
- Zigzag: k even -> k/2; k odd -> S-1-(k-1)/2. Example for S = 4: 0, 3, 1, 2.
- Plane order within a row: bit 0 up to bitdepth-1, then k advances.
- k wraps from S-1 to 0, which is the frame boundary.

SHIFT:
- Each column takes 2 clk cycles; disp_clk is low in the first and high in the second.
- mem_addr is issued 1 cycle ahead. disp_rgb changes only while disp_clk is low.
- Exactly n_cols rising edges per plane. disp_clk ends low.

Plane timing:
- Latch sequence for plane (row r, bit b), three cycles:
  - BL: disp_blank = 1, disp_addr = r;
  - LT: disp_latch = 1;
  - ON: disp_blank = 0.
- On-time is max(0, lsb_blank - brightness) << b cycles. If brightness >= lsb_blank the display stays blanked.
- Period is lsb_blank << b cycles, counted from ON.
- Shifting of the next plane starts in the cycle after LT, overlapping the period.
- The next BL occurs only when both the period has elapsed and the shift is done. When shifting is longer, the extra cycles are spent blanked.

Frame boundary:
- Occurs in the BL cycle of the first plane of k = 0, after at least one full frame.
- In that cycle, pulse stat_frame_done and set stat_buffer = mem_buffer = ctrl_buffer_req sampled in that cycle.
- A ctrl_buffer_req change mid-frame never alters the buffer being read.

Disable and reset:
- ctrl_en = 0 in any state: go to IDLE next cycle with disp_blank = 1, disp_clk = 0, disp_latch = 0.
- ctrl_rst mid-operation takes the full reset values the next cycle. ctrl_rst has priority over ctrl_en.

Arithmetic:
- Counters are sized for LSB_BLANK_MAX << (BITDEPTH_MAX-1).
- mem_addr product is truncated to ADDR_W.

Test Plan:
- Reset, then ctrl_en with rows = 4, cols = 4, bitdepth = 2, lsb = 20, brightness = 0, linear -> disp_addr sequence 0, 0, 1, 1; 4 disp_clk rises per plane; disp_blank low for 20 cycles, then 40 cycles.
- Same config, brightness = 5 -> on-times 15 and 30; plane periods stay 20 and 40.
- Zigzag, rows = 8, bitdepth = 1 -> disp_addr sequence 0, 3, 1, 2, 0; stat_frame_done pulses at the second 0.
- cols = 64, lsb = 4 (shift of 128 cycles exceeds the period) -> plane spacing = 128 + 3 cycles; blank stays high after the on-time.
- Toggle ctrl_buffer_req mid-frame -> mem_buffer changes only at the next stat_frame_done cycle.
- rows = 3 -> stat_cfg_err = 1, disp_blank held 1, no disp_clk edges. Then ctrl_en = 0, set rows = 4, ctrl_en = 1 -> stat_cfg_err clears and scanning runs.
